// File: rtl/valve_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : valve_pkg
//  Brief    : Shared types for the valve scheduler (FSM states, status codes,
//             valve masks) and a popcount helper for valve masks.
//  Revision : 1.0  initial release
// ============================================================================
package valve_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SERVE1     = 3'd1,
    SERVE2     = 3'd2,
    SERVE_BOTH = 3'd3,
    GUARD      = 3'd4,
    FAULT      = 3'd5
  } sched_state_t;

  typedef enum logic [1:0] {
    E_NONE  = 2'b00,
    E_LEVEL = 2'b01,
    E_CLIP  = 2'b10
  } err_t;

  typedef logic [1:0] valve_mask_t;

  // Number of valves a mask asks to open (0..2), sized so two results add without overflow
  function automatic logic [2:0] popcount(input valve_mask_t m);
    return {2'b00, m[0]} + {2'b00, m[1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/valve_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : valve_scheduler_if
//  Brief    : Request/enable bundle between the group request sources and the
//             valve drivers; the scheduler is the slave side.
//  Revision : 1.0  initial release
// ============================================================================
interface valve_scheduler_if;
  import valve_pkg::*;

  valve_mask_t G1;
  valve_mask_t G2;
  logic        lvl_fault;
  valve_mask_t R1;
  valve_mask_t R2;
  err_t        E;
  logic [1:0]  grant;

  modport master (output G1, output G2, output lvl_fault,
                  input  R1, input  R2, input  E, input  grant);

  modport slave  (input  G1, input  G2, input  lvl_fault,
                  output R1, output R2, output E, output grant);

endinterface
`default_nettype wire

// File: rtl/valve_scheduler_slice_timer.sv
`default_nettype none
// ============================================================================
//  Module   : slice_timer
//  Brief    : Loadable down-counter timing grant slices and guard gaps.
//             It parks at zero; expired flags the last cycle of an interval.
//  Revision : 1.0  initial release
// ============================================================================
module slice_timer #(
  parameter int WIDTH = 5
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] load_val,
  output logic                  expired
);

  logic [WIDTH-1:0] r_count;

  // Count down toward zero; a load restarts the interval at the next edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_count <= '0;
    else if (load)            r_count <= load_val;
    else if (r_count != '0)   r_count <= r_count - 1'b1;
  end

  // Only the count is decoded here so the caller may decide its load from this
  // flag without forming a loop; a same-cycle load still wins at the edge.
  assign expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/valve_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : valve_scheduler
//  Brief    : Shares one water supply between two valve groups: capacity
//             limit, round-robin time slices, all-closed guard gaps between
//             grants and a forced close on tank-level fault.
//  Revision : 1.0  initial release
// ============================================================================
module valve_scheduler
  import valve_pkg::*;
#(
  parameter int SLICE_CYCLES = 16,
  parameter int GUARD_CYCLES = 2,
  parameter int MAX_OPEN     = 2
) (
  input  wire logic         clk,
  input  wire logic         reset,
  valve_scheduler_if.slave  bus
);

  localparam int c_TIMER_W =
    $clog2(((SLICE_CYCLES > GUARD_CYCLES) ? SLICE_CYCLES : GUARD_CYCLES) + 1);
  localparam logic [c_TIMER_W-1:0] c_SLICE_LOAD = c_TIMER_W'(SLICE_CYCLES - 1);
  localparam logic [c_TIMER_W-1:0] c_GUARD_LOAD = c_TIMER_W'(GUARD_CYCLES - 1);
  localparam logic [2:0]           c_MAX_OPEN   = 3'(MAX_OPEN);

  sched_state_t           r_state, w_state_nxt, w_dec_state;
  logic                   r_rr, w_rr_nxt, w_dec_toggle;   // 0 = G1 preferred
  valve_mask_t            r_m1, r_m2, w_m1_nxt, w_m2_nxt;
  logic                   r_clip, w_clip_nxt;
  logic                   w_g1_on, w_g2_on, w_restart;
  logic                   w_serve1_nxt, w_serve2_nxt, w_enter_serve;
  logic [2:0]             w_pair_sum;
  logic                   w_load, w_expired;
  logic [c_TIMER_W-1:0]   w_load_val;

  // A single group asking for more than the supply allows keeps valve A only
  function automatic valve_mask_t clip_mask(input valve_mask_t m);
    return (popcount(m) > c_MAX_OPEN) ? {1'b0, m[0]} : m;
  endfunction

  slice_timer #(.WIDTH(c_TIMER_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .load_val (w_load_val),
    .expired  (w_expired)
  );

  assign w_g1_on    = |bus.G1;
  assign w_g2_on    = |bus.G2;
  assign w_pair_sum = popcount(bus.G1) + popcount(bus.G2);

  // Arbitration of live requests: capacity rule first, then the round-robin pointer
  always_comb begin
    w_dec_state  = IDLE;
    w_dec_toggle = 1'b0;
    if (w_g1_on && w_g2_on) begin
      if (w_pair_sum <= c_MAX_OPEN) begin
        w_dec_state = SERVE_BOTH;
      end else begin
        w_dec_state  = r_rr ? SERVE2 : SERVE1;
        w_dec_toggle = 1'b1;
      end
    end else if (w_g1_on) begin
      w_dec_state  = SERVE1;
      w_dec_toggle = 1'b1;
    end else if (w_g2_on) begin
      w_dec_state  = SERVE2;
      w_dec_toggle = 1'b1;
    end
  end

  // Next state: fault beats everything, a served group dropping beats slice expiry
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr;
    w_restart   = 1'b0;
    if (bus.lvl_fault) begin
      w_state_nxt = FAULT;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = w_dec_state;
          w_rr_nxt    = r_rr ^ w_dec_toggle;
        end
        SERVE1: begin
          if (!w_g1_on)                    w_state_nxt = GUARD;
          else if (w_expired && w_g2_on)   w_state_nxt = GUARD;
          else if (w_expired)              w_restart   = 1'b1;
        end
        SERVE2: begin
          if (!w_g2_on)                    w_state_nxt = GUARD;
          else if (w_expired && w_g1_on)   w_state_nxt = GUARD;
          else if (w_expired)              w_restart   = 1'b1;
        end
        SERVE_BOTH: begin
          if (!w_g1_on || !w_g2_on || w_expired) w_state_nxt = GUARD;
        end
        GUARD: begin
          if (w_expired) begin
            w_state_nxt = w_dec_state;
            w_rr_nxt    = r_rr ^ w_dec_toggle;
          end
        end
        FAULT:   w_state_nxt = GUARD;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Mask latching and timer loads on entry to a slice or a guard gap
  always_comb begin
    w_serve1_nxt  = (w_state_nxt == SERVE1) || (w_state_nxt == SERVE_BOTH);
    w_serve2_nxt  = (w_state_nxt == SERVE2) || (w_state_nxt == SERVE_BOTH);
    w_enter_serve = (w_serve1_nxt || w_serve2_nxt) &&
                    ((w_state_nxt != r_state) || w_restart);
    w_load        = 1'b0;
    w_load_val    = c_SLICE_LOAD;
    w_m1_nxt      = r_m1;
    w_m2_nxt      = r_m2;
    w_clip_nxt    = r_clip;
    if (w_enter_serve) begin
      w_load     = 1'b1;
      w_m1_nxt   = w_serve1_nxt ? clip_mask(bus.G1) : 2'b00;
      w_m2_nxt   = w_serve2_nxt ? clip_mask(bus.G2) : 2'b00;
      w_clip_nxt = (w_serve1_nxt && (popcount(bus.G1) > c_MAX_OPEN)) ||
                   (w_serve2_nxt && (popcount(bus.G2) > c_MAX_OPEN));
    end else if (!(w_serve1_nxt || w_serve2_nxt)) begin
      w_m1_nxt   = 2'b00;
      w_m2_nxt   = 2'b00;
      w_clip_nxt = 1'b0;
      if ((w_state_nxt == GUARD) && (r_state != GUARD)) begin
        w_load     = 1'b1;
        w_load_val = c_GUARD_LOAD;
      end
    end
  end

  // State register with round-robin pointer and latched slice masks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_rr    <= 1'b0;
      r_m1    <= 2'b00;
      r_m2    <= 2'b00;
      r_clip  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rr    <= w_rr_nxt;
      r_m1    <= w_m1_nxt;
      r_m2    <= w_m2_nxt;
      r_clip  <= w_clip_nxt;
    end
  end

  // Registered valve enables and status, decoded from the upcoming state and masks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.R1    <= 2'b00;
      bus.R2    <= 2'b00;
      bus.E     <= E_NONE;
      bus.grant <= 2'b00;
    end else begin
      bus.R1    <= w_m1_nxt;
      bus.R2    <= w_m2_nxt;
      bus.grant <= {w_serve2_nxt, w_serve1_nxt};
      bus.E     <= (w_state_nxt == FAULT) ? E_LEVEL :
                   (w_clip_nxt ? E_CLIP : E_NONE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_valve_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_valve_scheduler
//  Brief    : Self-checking bench: per-cycle expected {R1,R2,E,grant} queued
//             with each stimulus, popped and compared one cycle at a time.
//             dut_a runs MAX_OPEN=2, dut_b runs MAX_OPEN=1.
//  Revision : 1.0  initial release
// ============================================================================
module tb_valve_scheduler;
  import valve_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  valve_scheduler_if bus_a();
  valve_scheduler_if bus_b();

  valve_scheduler #(.SLICE_CYCLES(16), .GUARD_CYCLES(2), .MAX_OPEN(2)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  valve_scheduler #(.SLICE_CYCLES(16), .GUARD_CYCLES(2), .MAX_OPEN(1)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];   // packed {R1, R2, E, grant}

  localparam logic [7:0] c_ZERO = 8'b00_00_00_00;

  function automatic logic [7:0] pk(input logic [1:0] r1, input logic [1:0] r2,
                                    input logic [1:0] e,  input logic [1:0] gr);
    return {r1, r2, e, gr};
  endfunction

  function automatic logic [7:0] obs(input bit use_b);
    if (use_b) return {bus_b.R1, bus_b.R2, bus_b.E, bus_b.grant};
    return {bus_a.R1, bus_a.R2, bus_a.E, bus_a.grant};
  endfunction

  function automatic int pop2(input logic [1:0] m);
    return int'(m[0]) + int'(m[1]);
  endfunction

  task automatic push(input logic [7:0] v, input int n);
    repeat (n) q.push_back(v);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    bus_a.G1 = 2'b00; bus_a.G2 = 2'b00; bus_a.lvl_fault = 1'b0;
    bus_b.G1 = 2'b00; bus_b.G2 = 2'b00; bus_b.lvl_fault = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    logic [7:0] got, exp;
    int cyc = 0;
    @(negedge clk);
    checks++;
    if (obs(0) !== c_ZERO) begin
      errors++; $display("FAIL reset_a: R1|R2|E|grant got %b expected %b", obs(0), c_ZERO);
    end
    checks++;
    if (obs(1) !== c_ZERO) begin
      errors++; $display("FAIL reset_b: R1|R2|E|grant got %b expected %b", obs(1), c_ZERO);
    end
    @(posedge clk); #1 reset = 1'b0;
    push(c_ZERO, 3);
    while (q.size() > 0) begin
      @(posedge clk); #1;
      exp = q.pop_front(); got = obs(0); cyc++; checks++;
      if (got !== exp) begin
        errors++; $display("FAIL idle_after_reset cyc %0d: got %b expected %b", cyc, got, exp);
      end
    end
  endtask

  task automatic test_single_reslice();
    logic [7:0] got, exp;
    int cyc = 0;
    do_reset();
    bus_a.G1 = 2'b01;
    push(pk(2'b01, 2'b00, 2'b00, 2'b01), 40);
    while (q.size() > 0) begin
      @(posedge clk); #1;
      exp = q.pop_front(); got = obs(0); cyc++; checks++;
      if (got !== exp) begin
        errors++; $display("FAIL single_reslice cyc %0d: got %b expected %b", cyc, got, exp);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] got, exp;
    int cyc = 0;
    do_reset();
    bus_a.G1 = 2'b11; bus_a.G2 = 2'b11;
    push(pk(2'b11, 2'b00, 2'b00, 2'b01), 16);
    push(c_ZERO, 2);
    push(pk(2'b00, 2'b11, 2'b00, 2'b10), 16);
    push(c_ZERO, 2);
    push(pk(2'b11, 2'b00, 2'b00, 2'b01), 16);
    while (q.size() > 0) begin
      @(posedge clk); #1;
      exp = q.pop_front(); got = obs(0); cyc++; checks++;
      if (got !== exp) begin
        errors++; $display("FAIL round_robin cyc %0d: got %b expected %b", cyc, got, exp);
      end
    end
  endtask

  task automatic test_serve_both();
    logic [7:0] got, exp;
    int cyc = 0;
    do_reset();
    bus_a.G1 = 2'b01; bus_a.G2 = 2'b10;
    push(pk(2'b01, 2'b10, 2'b00, 2'b11), 16);
    push(c_ZERO, 2);
    push(pk(2'b01, 2'b10, 2'b00, 2'b11), 3);
    while (q.size() > 0) begin
      @(posedge clk); #1;
      exp = q.pop_front(); got = obs(0); cyc++; checks++;
      if (got !== exp) begin
        errors++; $display("FAIL serve_both cyc %0d: got %b expected %b", cyc, got, exp);
      end
    end
    bus_a.G2 = 2'b00;
    push(c_ZERO, 2);
    push(pk(2'b01, 2'b00, 2'b00, 2'b01), 4);
    while (q.size() > 0) begin
      @(posedge clk); #1;
      exp = q.pop_front(); got = obs(0); cyc++; checks++;
      if (got !== exp) begin
        errors++; $display("FAIL both_drop cyc %0d: got %b expected %b", cyc, got, exp);
      end
    end
  endtask

  task automatic test_level_fault();
    logic [7:0] got, exp;
    int cyc = 0;
    do_reset();
    bus_a.G1 = 2'b01;
    push(pk(2'b01, 2'b00, 2'b00, 2'b01), 5);
    while (q.size() > 0) begin
      @(posedge clk); #1;
      exp = q.pop_front(); got = obs(0); cyc++; checks++;
      if (got !== exp) begin
        errors++; $display("FAIL fault_pre cyc %0d: got %b expected %b", cyc, got, exp);
      end
    end
    bus_a.lvl_fault = 1'b1;
    push(pk(2'b00, 2'b00, 2'b01, 2'b00), 3);
    while (q.size() > 0) begin
      @(posedge clk); #1;
      exp = q.pop_front(); got = obs(0); cyc++; checks++;
      if (got !== exp) begin
        errors++; $display("FAIL fault_hold cyc %0d: got %b expected %b", cyc, got, exp);
      end
    end
    bus_a.lvl_fault = 1'b0;
    push(c_ZERO, 2);
    push(pk(2'b01, 2'b00, 2'b00, 2'b01), 3);
    while (q.size() > 0) begin
      @(posedge clk); #1;
      exp = q.pop_front(); got = obs(0); cyc++; checks++;
      if (got !== exp) begin
        errors++; $display("FAIL fault_release cyc %0d: got %b expected %b", cyc, got, exp);
      end
    end
  endtask

  task automatic test_clip();
    logic [7:0] got, exp;
    int cyc = 0;
    do_reset();
    bus_b.G1 = 2'b11;
    push(pk(2'b01, 2'b00, 2'b10, 2'b01), 20);
    while (q.size() > 0) begin
      @(posedge clk); #1;
      exp = q.pop_front(); got = obs(1); cyc++; checks++;
      if (got !== exp) begin
        errors++; $display("FAIL clip cyc %0d: got %b expected %b", cyc, got, exp);
      end
      checks++;
      if (pop2(bus_b.R1) + pop2(bus_b.R2) > 1) begin
        errors++; $display("FAIL clip_invariant cyc %0d: open valves %0d, limit 1",
                           cyc, pop2(bus_b.R1) + pop2(bus_b.R2));
      end
    end
  endtask

  task automatic test_capacity_limit();
    logic [7:0] got, exp;
    int cyc = 0;
    do_reset();
    bus_b.G1 = 2'b01; bus_b.G2 = 2'b01;
    push(pk(2'b01, 2'b00, 2'b00, 2'b01), 16);
    push(c_ZERO, 2);
    push(pk(2'b00, 2'b01, 2'b00, 2'b10), 2);
    while (q.size() > 0) begin
      @(posedge clk); #1;
      exp = q.pop_front(); got = obs(1); cyc++; checks++;
      if (got !== exp) begin
        errors++; $display("FAIL capacity cyc %0d: got %b expected %b", cyc, got, exp);
      end
      checks++;
      if (pop2(bus_b.R1) + pop2(bus_b.R2) > 1) begin
        errors++; $display("FAIL capacity_invariant cyc %0d: open valves %0d, limit 1",
                           cyc, pop2(bus_b.R1) + pop2(bus_b.R2));
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] got, exp;
    int cyc = 0;
    do_reset();
    bus_a.G1 = 2'b11; bus_a.G2 = 2'b11;
    push(pk(2'b11, 2'b00, 2'b00, 2'b01), 16);
    push(c_ZERO, 2);
    push(pk(2'b00, 2'b11, 2'b00, 2'b10), 3);
    while (q.size() > 0) begin
      @(posedge clk); #1;
      exp = q.pop_front(); got = obs(0); cyc++; checks++;
      if (got !== exp) begin
        errors++; $display("FAIL pre_reset cyc %0d: got %b expected %b", cyc, got, exp);
      end
    end
    #3 reset = 1'b1;
    #1;
    checks++;
    if (obs(0) !== c_ZERO) begin
      errors++; $display("FAIL async_reset_close: got %b expected %b", obs(0), c_ZERO);
    end
    #1 reset = 1'b0;
    push(pk(2'b11, 2'b00, 2'b00, 2'b01), 2);
    while (q.size() > 0) begin
      @(posedge clk); #1;
      exp = q.pop_front(); got = obs(0); cyc++; checks++;
      if (got !== exp) begin
        errors++; $display("FAIL post_reset_rr cyc %0d: got %b expected %b", cyc, got, exp);
      end
    end
  endtask

  initial begin
    bus_a.G1 = 2'b00; bus_a.G2 = 2'b00; bus_a.lvl_fault = 1'b0;
    bus_b.G1 = 2'b00; bus_b.G2 = 2'b00; bus_b.lvl_fault = 1'b0;
    test_reset();
    test_single_reslice();
    test_round_robin();
    test_serve_both();
    test_level_fault();
    test_clip();
    test_capacity_limit();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
